// File: rtl/a3_cpu_pkg.sv
// Shared A3 CPU front-end definitions: fetch FSM encoding, the bus control
// opcode for an instruction read, and default fetch geometry.
package a3_cpu_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } fetch_state_t;

  // Opcode understood by the bus ctl decoder as "read at address".
  localparam logic [7:0] CTL_OP_READ_ADDR = 8'h02;

  // Default PC increment and reset vector of the A3 front end.
  localparam int unsigned DEFAULT_STEP      = 32'd4;
  localparam int unsigned DEFAULT_RESET_VEC = 32'd0;

endpackage

// File: rtl/pc_fetch_ctl.sv
// Program counter and fetch-request sequencer for the A3 front end.
// Issues one read request per instruction on a valid/ready control channel,
// tags the returned word with its PC and handles redirects and inhibit.
// A redirect that lands while a request is accepted but unanswered marks the
// outstanding response for discard, so a stale word never reaches decode.
module pc_fetch_ctl
  import a3_cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32'd17,
  parameter int unsigned CTL_WIDTH   = 32'd64,
  parameter int unsigned OP_WIDTH    = 32'd8,
  parameter int unsigned INSTR_WIDTH = 32'd8,
  parameter int unsigned STEP        = DEFAULT_STEP,
  parameter int unsigned RESET_VEC   = DEFAULT_RESET_VEC,
  parameter logic [OP_WIDTH-1:0] CTL_READ_ADDR = OP_WIDTH'(CTL_OP_READ_ADDR)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_inhibit,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  input  logic                   ctl_ready,
  input  logic                   bus_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] bus_data_in,
  output logic                   ctl_valid,
  output logic [OP_WIDTH-1:0]    ctl_op_out,
  output logic [CTL_WIDTH-1:0]   ctl_data_out,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  // Redirect targets are forced onto a STEP boundary.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 32'd1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_VEC);

  fetch_state_t            state_r;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic                    discard_r;

  logic [ADDR_WIDTH-1:0]   target_s;
  logic [ADDR_WIDTH-1:0]   pc_next_s;
  logic                    deliver_s;

  // Next-PC mux: redirect beats increment, increment only on a kept response.
  always_comb begin
    target_s  = redirect_addr & ALIGN_MASK;
    deliver_s = 1'b0;
    pc_next_s = pc_r;
    if (state_r == WAIT && bus_rsp_valid && !discard_r && !redirect_valid) begin
      deliver_s = 1'b1;
    end else begin
      deliver_s = 1'b0;
    end
    if (redirect_valid) begin
      pc_next_s = target_s;
    end else if (deliver_s) begin
      pc_next_s = pc_r + PC_STEP;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Fetch FSM with registered request and instruction outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      discard_r    <= 1'b0;
      ctl_valid    <= 1'b0;
      ctl_op_out   <= {OP_WIDTH{1'b0}};
      ctl_data_out <= {CTL_WIDTH{1'b0}};
      instr_valid  <= 1'b0;
      instr_out    <= {INSTR_WIDTH{1'b0}};
      instr_pc     <= {ADDR_WIDTH{1'b0}};
    end else begin
      pc_r        <= pc_next_s;
      instr_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          // A redirect here only moves the PC; the issue decision still follows inhibit.
          if (!pc_inhibit) begin
            state_r      <= ISSUE;
            ctl_valid    <= 1'b1;
            ctl_op_out   <= CTL_READ_ADDR;
            ctl_data_out <= CTL_WIDTH'(pc_next_s);
          end else begin
            state_r      <= IDLE;
            ctl_valid    <= 1'b0;
            ctl_op_out   <= {OP_WIDTH{1'b0}};
            ctl_data_out <= {CTL_WIDTH{1'b0}};
          end
        end
        ISSUE: begin
          if (ctl_ready) begin
            // Accepted: a same-cycle redirect makes the coming response stale.
            state_r      <= WAIT;
            discard_r    <= redirect_valid;
            ctl_valid    <= 1'b0;
            ctl_op_out   <= {OP_WIDTH{1'b0}};
            ctl_data_out <= {CTL_WIDTH{1'b0}};
          end else if (redirect_valid) begin
            // Not yet accepted: withdraw and let IDLE reissue at the new PC.
            state_r      <= IDLE;
            ctl_valid    <= 1'b0;
            ctl_op_out   <= {OP_WIDTH{1'b0}};
            ctl_data_out <= {CTL_WIDTH{1'b0}};
          end else begin
            // Inhibit never withdraws a presented request; hold it stable.
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            if (deliver_s) begin
              instr_valid <= 1'b1;
              instr_out   <= bus_data_in;
              instr_pc    <= pc_r;
            end else begin
              instr_valid <= 1'b0;
            end
            discard_r <= 1'b0;
            if (!pc_inhibit) begin
              state_r      <= ISSUE;
              ctl_valid    <= 1'b1;
              ctl_op_out   <= CTL_READ_ADDR;
              ctl_data_out <= CTL_WIDTH'(pc_next_s);
            end else begin
              state_r      <= IDLE;
              ctl_valid    <= 1'b0;
              ctl_op_out   <= {OP_WIDTH{1'b0}};
              ctl_data_out <= {CTL_WIDTH{1'b0}};
            end
          end else if (redirect_valid) begin
            state_r   <= WAIT;
            discard_r <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          state_r      <= IDLE;
          discard_r    <= 1'b0;
          ctl_valid    <= 1'b0;
          ctl_op_out   <= {OP_WIDTH{1'b0}};
          ctl_data_out <= {CTL_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign pc_out = pc_r;

endmodule

// File: tb/tb_pc_fetch_ctl.sv
// Directed bench for pc_fetch_ctl: default geometry instance plus a 4-bit
// PC instance with reset vector 12 for the wrap case.
module tb_pc_fetch_ctl;

  logic        clk;
  logic        reset;
  logic        pc_inhibit;
  logic        redirect_valid;
  logic [16:0] redirect_addr;
  logic        ctl_ready;
  logic        bus_rsp_valid;
  logic [7:0]  bus_data_in;
  logic        ctl_valid;
  logic [7:0]  ctl_op_out;
  logic [63:0] ctl_data_out;
  logic        instr_valid;
  logic [7:0]  instr_out;
  logic [16:0] instr_pc;
  logic [16:0] pc_out;

  logic        w_pc_inhibit;
  logic        w_redirect_valid;
  logic [3:0]  w_redirect_addr;
  logic        w_ctl_ready;
  logic        w_bus_rsp_valid;
  logic [7:0]  w_bus_data_in;
  logic        w_ctl_valid;
  logic [7:0]  w_ctl_op_out;
  logic [63:0] w_ctl_data_out;
  logic        w_instr_valid;
  logic [7:0]  w_instr_out;
  logic [3:0]  w_instr_pc;
  logic [3:0]  w_pc_out;

  int n_checks;
  int n_fail;

  pc_fetch_ctl dut (
    .clk(clk), .reset(reset), .pc_inhibit(pc_inhibit),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .ctl_ready(ctl_ready), .bus_rsp_valid(bus_rsp_valid), .bus_data_in(bus_data_in),
    .ctl_valid(ctl_valid), .ctl_op_out(ctl_op_out), .ctl_data_out(ctl_data_out),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .pc_out(pc_out)
  );

  pc_fetch_ctl #(.ADDR_WIDTH(32'd4), .RESET_VEC(32'd12)) dut_w (
    .clk(clk), .reset(reset), .pc_inhibit(w_pc_inhibit),
    .redirect_valid(w_redirect_valid), .redirect_addr(w_redirect_addr),
    .ctl_ready(w_ctl_ready), .bus_rsp_valid(w_bus_rsp_valid), .bus_data_in(w_bus_data_in),
    .ctl_valid(w_ctl_valid), .ctl_op_out(w_ctl_op_out), .ctl_data_out(w_ctl_data_out),
    .instr_valid(w_instr_valid), .instr_out(w_instr_out), .instr_pc(w_instr_pc),
    .pc_out(w_pc_out)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_inhibit = 1'b1; redirect_valid = 1'b0; redirect_addr = 17'h00000;
    ctl_ready = 1'b0; bus_rsp_valid = 1'b0; bus_data_in = 8'h00;
    w_pc_inhibit = 1'b1; w_redirect_valid = 1'b0; w_redirect_addr = 4'h0;
    w_ctl_ready = 1'b0; w_bus_rsp_valid = 1'b0; w_bus_data_in = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Reset before any clock edge.
    idle_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (pc_out !== 17'h00000) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc_out, 17'h00000); end
    n_checks++; if (ctl_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ctl_valid: got %b want 0", ctl_valid); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    n_checks++; if (w_pc_out !== 4'hC) begin n_fail++; $display("FAIL rst_w_pc: got %h want c", w_pc_out); end
    step();
    reset = 1'b0;
    // Advance to WAIT with pc=4, then assert reset between edges.
    pc_inhibit = 1'b0; ctl_ready = 1'b1;
    step(); step();
    bus_rsp_valid = 1'b1; bus_data_in = 8'h11;
    step();
    bus_rsp_valid = 1'b0;
    step();
    n_checks++; if (pc_out !== 17'h00004) begin n_fail++; $display("FAIL rst_pre_pc: got %h want %h", pc_out, 17'h00004); end
    bus_rsp_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (pc_out !== 17'h00000) begin n_fail++; $display("FAIL rst_async_pc: got %h want 0", pc_out); end
    n_checks++; if (instr_pc !== 17'h00000) begin n_fail++; $display("FAIL rst_async_instr_pc: got %h want 0", instr_pc); end
    n_checks++; if (instr_out !== 8'h00) begin n_fail++; $display("FAIL rst_async_instr_out: got %h want 0", instr_out); end
    n_checks++; if (ctl_op_out !== 8'h00) begin n_fail++; $display("FAIL rst_async_op: got %h want 0", ctl_op_out); end
    n_checks++; if (ctl_data_out !== 64'h0) begin n_fail++; $display("FAIL rst_async_data: got %h want 0", ctl_data_out); end
    step();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_held_instr_valid: got %b want 0", instr_valid); end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    do_reset();
    pc_inhibit = 1'b0; ctl_ready = 1'b1;
    step();
    n_checks++; if (ctl_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid0: got %b want 1", ctl_valid); end
    n_checks++; if (ctl_data_out !== 64'h0) begin n_fail++; $display("FAIL basic_addr0: got %h want 0", ctl_data_out); end
    n_checks++; if (ctl_op_out !== 8'h02) begin n_fail++; $display("FAIL basic_op0: got %h want 02", ctl_op_out); end
    step();
    n_checks++; if (ctl_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_valid: got %b want 0", ctl_valid); end
    n_checks++; if (ctl_op_out !== 8'h00) begin n_fail++; $display("FAIL basic_wait_op: got %h want 00", ctl_op_out); end
    bus_rsp_valid = 1'b1; bus_data_in = 8'hA5;
    step();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_iv0: got %b want 1", instr_valid); end
    n_checks++; if (instr_out !== 8'hA5) begin n_fail++; $display("FAIL basic_instr0: got %h want a5", instr_out); end
    n_checks++; if (instr_pc !== 17'h00000) begin n_fail++; $display("FAIL basic_ipc0: got %h want 0", instr_pc); end
    n_checks++; if (pc_out !== 17'h00004) begin n_fail++; $display("FAIL basic_pc4: got %h want 4", pc_out); end
    n_checks++; if (ctl_data_out !== 64'h4) begin n_fail++; $display("FAIL basic_addr4: got %h want 4", ctl_data_out); end
    n_checks++; if (ctl_op_out !== 8'h02) begin n_fail++; $display("FAIL basic_op4: got %h want 02", ctl_op_out); end
    bus_rsp_valid = 1'b0;
    step();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_iv_gap: got %b want 0", instr_valid); end
    bus_rsp_valid = 1'b1; bus_data_in = 8'h3C;
    step();
    n_checks++; if (instr_out !== 8'h3C) begin n_fail++; $display("FAIL basic_instr1: got %h want 3c", instr_out); end
    n_checks++; if (instr_pc !== 17'h00004) begin n_fail++; $display("FAIL basic_ipc1: got %h want 4", instr_pc); end
    n_checks++; if (pc_out !== 17'h00008) begin n_fail++; $display("FAIL basic_pc8: got %h want 8", pc_out); end
  endtask

  task automatic test_ready_stall();
    do_reset();
    pc_inhibit = 1'b0; ctl_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (ctl_valid !== 1'b1 || ctl_data_out !== 64'h0) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b addr=%h want valid=1 addr=0", i, ctl_valid, ctl_data_out); end
      if (i == 4) ctl_ready = 1'b1;
      step();
    end
    n_checks++; if (ctl_valid !== 1'b0) begin n_fail++; $display("FAIL stall_accept: got %b want 0", ctl_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    pc_inhibit = 1'b0; ctl_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_addr = 17'h00107;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_out !== 17'h00104) begin n_fail++; $display("FAIL rdw_pc: got %h want 104", pc_out); end
    n_checks++; if (ctl_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_valid: got %b want 0", ctl_valid); end
    bus_rsp_valid = 1'b1; bus_data_in = 8'h55;
    step();
    bus_rsp_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: got %b want 0", instr_valid); end
    n_checks++; if (pc_out !== 17'h00104) begin n_fail++; $display("FAIL rdw_no_inc: got %h want 104", pc_out); end
    n_checks++; if (ctl_valid !== 1'b1 || ctl_data_out !== 64'h104) begin n_fail++; $display("FAIL rdw_reissue: got valid=%b addr=%h want valid=1 addr=104", ctl_valid, ctl_data_out); end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    pc_inhibit = 1'b0; ctl_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_addr = 17'h00020;
    bus_rsp_valid = 1'b1; bus_data_in = 8'hEE;
    step();
    redirect_valid = 1'b0; bus_rsp_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdc_dropped: got %b want 0", instr_valid); end
    n_checks++; if (pc_out !== 17'h00020) begin n_fail++; $display("FAIL rdc_pc: got %h want 20", pc_out); end
    n_checks++; if (ctl_data_out !== 64'h20) begin n_fail++; $display("FAIL rdc_addr: got %h want 20", ctl_data_out); end
  endtask

  task automatic test_redirect_issue();
    do_reset();
    pc_inhibit = 1'b0; ctl_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_addr = 17'h00043;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (ctl_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_withdraw: got %b want 0", ctl_valid); end
    n_checks++; if (pc_out !== 17'h00040) begin n_fail++; $display("FAIL rdi_pc: got %h want 40", pc_out); end
    step();
    n_checks++; if (ctl_valid !== 1'b1 || ctl_data_out !== 64'h40) begin n_fail++; $display("FAIL rdi_reissue: got valid=%b addr=%h want valid=1 addr=40", ctl_valid, ctl_data_out); end
  endtask

  task automatic test_inhibit_wait();
    do_reset();
    pc_inhibit = 1'b0; ctl_ready = 1'b1;
    step(); step();
    pc_inhibit = 1'b1; bus_rsp_valid = 1'b1; bus_data_in = 8'h77;
    step();
    bus_rsp_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b1 || instr_out !== 8'h77) begin n_fail++; $display("FAIL inh_deliver: got iv=%b instr=%h want iv=1 instr=77", instr_valid, instr_out); end
    n_checks++; if (pc_out !== 17'h00004) begin n_fail++; $display("FAIL inh_pc: got %h want 4", pc_out); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ctl_valid !== 1'b0) begin n_fail++; $display("FAIL inh_idle[%0d]: got %b want 0", i, ctl_valid); end
      step();
    end
    pc_inhibit = 1'b0;
    step();
    n_checks++; if (ctl_valid !== 1'b1 || ctl_data_out !== 64'h4) begin n_fail++; $display("FAIL inh_release: got valid=%b addr=%h want valid=1 addr=4", ctl_valid, ctl_data_out); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_iv;
    exp_iv = 6'b010100;
    do_reset();
    pc_inhibit = 1'b0; ctl_ready = 1'b1; bus_rsp_valid = 1'b1; bus_data_in = 8'h99;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++; if (instr_valid !== exp_iv[i]) begin n_fail++; $display("FAIL b2b_iv[%0d]: got %b want %b", i, instr_valid, exp_iv[i]); end
    end
    n_checks++; if (pc_out !== 17'h00008) begin n_fail++; $display("FAIL b2b_pc: got %h want 8", pc_out); end
    bus_rsp_valid = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    w_pc_inhibit = 1'b0; w_ctl_ready = 1'b1;
    step();
    n_checks++; if (w_ctl_data_out !== 64'hC) begin n_fail++; $display("FAIL wrap_addr: got %h want c", w_ctl_data_out); end
    step();
    w_bus_rsp_valid = 1'b1; w_bus_data_in = 8'h9A;
    step();
    w_bus_rsp_valid = 1'b0;
    n_checks++; if (w_instr_pc !== 4'hC) begin n_fail++; $display("FAIL wrap_ipc: got %h want c", w_instr_pc); end
    n_checks++; if (w_pc_out !== 4'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", w_pc_out); end
    n_checks++; if (w_ctl_data_out !== 64'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 0", w_ctl_data_out); end
  endtask

  // Test sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_fetch();
    test_ready_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_redirect_issue();
    test_inhibit_wait();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
